// File: rtl/bid_round_arbiter_pkg.sv
// Shared types for the bids22 auction datapath: bid error codes, round FSM states
// and the bid cost helper used by the charge/refund path.
package bids22defs;

  typedef enum logic [2:0] {
    NOBIDERROR        = 3'd0,
    ROUNDINACTIVE     = 3'd1,
    INSUFFICIENTFUNDS = 3'd2,
    INVALIDREQUEST    = 3'd3
  } biderrors_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESOLVE,
    DONE
  } round_state_t;

  // Cost is formed at a generous width; callers cast down to DATAWIDTH+1 so the
  // carry out of amount+charge is never lost.
  localparam int BID_COST_W = 64;

  function automatic logic [BID_COST_W:0] bid_cost(input logic [BID_COST_W-1:0] amt,
                                                   input logic [BID_COST_W-1:0] charge);
    return {1'b0, amt} + {1'b0, charge};
  endfunction

endpackage

// File: rtl/bid_round_arbiter_rr.sv
// Round-robin pick: one-hot grant of the lowest requesting index at or after ptr,
// wrapping past N-1. Purely combinational.
module rr_arbiter #(
  parameter int N    = 3,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    // Walk from the farthest offset back to ptr so the nearest requester wins.
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bid_round_arbiter.sv
// Bidding round controller: owns balances, runs a timed round, serves one bid/retract
// per cycle through a round-robin arbiter and resolves the winner at round end.
module bid_round_arbiter
  import bids22defs::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int BIDAMTBITS = DATAWIDTH / 2,
  parameter int IDXW       = $clog2(NUMBIDDERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_load,
  input  logic [IDXW-1:0]                  cfg_idx,
  input  logic [DATAWIDTH-1:0]             cfg_data,
  input  logic [NUMBIDDERS-1:0]            mask,
  input  logic [DATAWIDTH-1:0]             timer,
  input  logic [DATAWIDTH-1:0]             bid_charge,
  input  logic                             round_start,
  input  logic [NUMBIDDERS-1:0]            bid,
  input  logic [NUMBIDDERS-1:0]            retract,
  input  logic [NUMBIDDERS*BIDAMTBITS-1:0] bid_amt,
  output logic [NUMBIDDERS-1:0]            ack,
  output logic [NUMBIDDERS*3-1:0]          bid_err,
  output logic [NUMBIDDERS*DATAWIDTH-1:0]  balance,
  output logic [NUMBIDDERS-1:0]            win,
  output logic                             round_active,
  output logic                             round_over,
  output logic [DATAWIDTH-1:0]             max_bid,
  output logic                             dup_bids
);

  localparam int N  = NUMBIDDERS;
  localparam int DW = DATAWIDTH;

  round_state_t          state;
  logic [DW-1:0]         bal_q     [N];
  logic [DW-1:0]         lastbid_q [N];
  logic [BIDAMTBITS-1:0] amt_q     [N];
  logic [BIDAMTBITS-1:0] amt_in    [N];
  logic [N-1:0]          pending_q;
  logic [N-1:0]          is_bid_q;
  logic [DW-1:0]         counter_q;
  logic [DW-1:0]         charge_q;
  logic [IDXW-1:0]       ptr_q;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? '1 : s[DW-1:0];
  endfunction

  logic [N-1:0]    req_any, new_req, arb_req, gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;

  assign req_any = bid | retract;
  assign new_req = req_any & ~pending_q;
  assign arb_req = (state == ACTIVE) ? (pending_q | new_req) : '0;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign amt_in[i]              = bid_amt[i*BIDAMTBITS +: BIDAMTBITS];
    assign balance[i*DW +: DW]    = bal_q[i];
  end

  rr_arbiter #(.N(N), .IDXW(IDXW)) u_arb (
    .req       (arb_req),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .valid     (gnt_vld)
  );

  // Service of the granted bidder; a request that arrives this cycle is served
  // straight from the inputs, an older one from its latched copy.
  logic                  g_is_bid;
  logic [BIDAMTBITS-1:0] g_amt;
  logic [DW:0]           avail, cost, diff;
  biderrors_t            svc_err;
  logic [DW-1:0]         svc_bal, svc_last;

  always_comb begin
    g_is_bid = pending_q[gnt_idx] ? is_bid_q[gnt_idx] : bid[gnt_idx];
    g_amt    = pending_q[gnt_idx] ? amt_q[gnt_idx] : amt_in[gnt_idx];
    avail    = {1'b0, bal_q[gnt_idx]} + {1'b0, lastbid_q[gnt_idx]};
    cost     = (DW+1)'(bid_cost(BID_COST_W'(g_amt), BID_COST_W'(charge_q)));
    diff     = avail - cost;
    svc_err  = NOBIDERROR;
    svc_bal  = bal_q[gnt_idx];
    svc_last = lastbid_q[gnt_idx];
    if (!mask[gnt_idx]) begin
      svc_err = INVALIDREQUEST;
    end else if (g_is_bid) begin
      if (cost > avail) begin
        svc_err = INSUFFICIENTFUNDS;
      end else begin
        svc_bal  = diff[DW] ? '1 : diff[DW-1:0];
        svc_last = DW'(g_amt);
      end
    end else begin
      svc_bal  = sat_add(bal_q[gnt_idx], lastbid_q[gnt_idx]);
      svc_last = '0;
    end
  end

  logic [DW-1:0] max_v;
  logic [N-1:0]  win_n;
  logic          dup_n;
  int            n_at_max;

  always_comb begin
    max_v    = '0;
    n_at_max = 0;
    win_n    = '0;
    for (int i = 0; i < N; i++)
      if (mask[i] && lastbid_q[i] > max_v) max_v = lastbid_q[i];
    for (int i = 0; i < N; i++)
      if (mask[i] && lastbid_q[i] == max_v) begin
        n_at_max = n_at_max + 1;
        win_n[i] = 1'b1;
      end
    dup_n = (max_v != '0) && (n_at_max > 1);
    if (max_v == '0 || n_at_max != 1) win_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ack          <= '0;
      bid_err      <= '0;
      win          <= '0;
      round_active <= 1'b0;
      round_over   <= 1'b0;
      max_bid      <= '0;
      dup_bids     <= 1'b0;
      pending_q    <= '0;
      is_bid_q     <= '0;
      counter_q    <= '0;
      charge_q     <= '0;
      ptr_q        <= '0;
      for (int i = 0; i < N; i++) begin
        bal_q[i]     <= '0;
        lastbid_q[i] <= '0;
        amt_q[i]     <= '0;
      end
    end else begin
      ack        <= '0;
      bid_err    <= '0;
      round_over <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) bal_q[cfg_idx] <= cfg_data;
          if (round_start && timer != '0) begin
            state        <= ACTIVE;
            round_active <= 1'b1;
            counter_q    <= timer;
            charge_q     <= bid_charge;
            win          <= '0;
            max_bid      <= '0;
            dup_bids     <= 1'b0;
            for (int i = 0; i < N; i++) lastbid_q[i] <= '0;
          end
        end
        ACTIVE: begin
          counter_q <= counter_q - 1'b1;
          if (counter_q == DW'(1)) begin
            state        <= RESOLVE;
            round_active <= 1'b0;
          end
          for (int i = 0; i < N; i++)
            if (new_req[i]) begin
              is_bid_q[i] <= bid[i];
              amt_q[i]    <= amt_in[i];
            end
          pending_q <= (pending_q | new_req) & ~gnt;
          if (gnt_vld) begin
            ack                     <= gnt;
            bid_err[gnt_idx*3 +: 3] <= svc_err;
            bal_q[gnt_idx]          <= svc_bal;
            lastbid_q[gnt_idx]      <= svc_last;
            ptr_q                   <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
          end
        end
        RESOLVE: begin
          max_bid    <= max_v;
          win        <= win_n;
          dup_bids   <= dup_n;
          round_over <= 1'b1;
          state      <= DONE;
          // Everyone except a sole winner gets their standing bid back.
          for (int i = 0; i < N; i++)
            if (!win_n[i]) begin
              bal_q[i]     <= sat_add(bal_q[i], lastbid_q[i]);
              lastbid_q[i] <= '0;
            end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Outside ACTIVE every request, and anything left pending, is bounced.
      if (state != ACTIVE) begin
        ack       <= req_any | pending_q;
        pending_q <= '0;
        for (int i = 0; i < N; i++)
          if (req_any[i] || pending_q[i]) bid_err[i*3 +: 3] <= ROUNDINACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_bid_round_arbiter.sv
// Directed bench for bid_round_arbiter: expected acks and round results are queued
// as stimulus is issued; a monitor pops and compares whenever the DUT responds.
module tb_bid_round_arbiter;
  import bids22defs::*;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int AB = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_load;
  logic [IW-1:0]   cfg_idx;
  logic [DW-1:0]   cfg_data;
  logic [N-1:0]    mask;
  logic [DW-1:0]   timer;
  logic [DW-1:0]   bid_charge;
  logic            round_start;
  logic [N-1:0]    bid;
  logic [N-1:0]    retract;
  logic [N*AB-1:0] bid_amt;
  logic [N-1:0]    ack;
  logic [N*3-1:0]  bid_err;
  logic [N*DW-1:0] balance;
  logic [N-1:0]    win;
  logic            round_active;
  logic            round_over;
  logic [DW-1:0]   max_bid;
  logic            dup_bids;

  always #5 clk = ~clk;

  bid_round_arbiter #(.DATAWIDTH(DW), .NUMBIDDERS(N), .BIDAMTBITS(AB), .IDXW(IW)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .mask(mask), .timer(timer), .bid_charge(bid_charge), .round_start(round_start),
    .bid(bid), .retract(retract), .bid_amt(bid_amt), .ack(ack), .bid_err(bid_err),
    .balance(balance), .win(win), .round_active(round_active), .round_over(round_over),
    .max_bid(max_bid), .dup_bids(dup_bids)
  );

  typedef struct {
    int            idx;
    logic [2:0]    err;
    logic          chk_bal;
    logic [DW-1:0] bal;
  } ack_exp_t;

  typedef struct {
    logic [N-1:0]          win;
    logic [DW-1:0]         max;
    logic                  dup;
    logic [N-1:0][DW-1:0]  bal;
  } round_exp_t;

  ack_exp_t   ackq[$];
  round_exp_t roundq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bal_of(input int i);
    return balance[i*DW +: DW];
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        for (int i = 0; i < N; i++) begin
          if (ack[i] === 1'b1) begin
            if (ackq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: bidder %0d acked with nothing expected", i);
            end else begin
              ack_exp_t e;
              e = ackq.pop_front();
              check("ack_order", 64'(i), 64'(e.idx));
              check($sformatf("ack_err%0d", i), 64'(bid_err[i*3 +: 3]), 64'(e.err));
              if (e.chk_bal) check($sformatf("ack_balance%0d", i), 64'(bal_of(i)), 64'(e.bal));
            end
          end
        end
        if (round_over === 1'b1) begin
          if (roundq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_round_over: got 1, expected 0");
          end else begin
            round_exp_t r;
            r = roundq.pop_front();
            check("round_win", 64'(win), 64'(r.win));
            check("round_max_bid", 64'(max_bid), 64'(r.max));
            check("round_dup_bids", 64'(dup_bids), 64'(r.dup));
            for (int i = 0; i < N; i++)
              check($sformatf("round_balance%0d", i), 64'(bal_of(i)), 64'(r.bal[i]));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic load3(input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    logic [N-1:0][DW-1:0] v;
    v = {b2, b1, b0};
    for (int i = 0; i < N; i++) begin
      cfg_load = 1'b1;
      cfg_idx  = IW'(i);
      cfg_data = v[i];
      cycle();
    end
    cfg_load = 1'b0;
  endtask

  task automatic start_round(input logic [DW-1:0] t, input logic [DW-1:0] ch);
    round_start = 1'b1;
    timer       = t;
    bid_charge  = ch;
    cycle();
    round_start = 1'b0;
  endtask

  task automatic request(input logic [N-1:0] b, input logic [N-1:0] r,
                         input logic [AB-1:0] a0, input logic [AB-1:0] a1, input logic [AB-1:0] a2);
    bid     = b;
    retract = r;
    bid_amt = {a2, a1, a0};
    cycle();
    bid     = '0;
    retract = '0;
    cycle();
  endtask

  task automatic expect_ack(input int idx, input biderrors_t err, input logic chk, input logic [DW-1:0] bal);
    ack_exp_t e;
    e.idx = idx; e.err = err; e.chk_bal = chk; e.bal = bal;
    ackq.push_back(e);
  endtask

  task automatic expect_round(input logic [N-1:0] w, input logic [DW-1:0] m, input logic d,
                              input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    round_exp_t r;
    r.win = w; r.max = m; r.dup = d; r.bal = {b2, b1, b0};
    roundq.push_back(r);
  endtask

  task automatic wait_round_over();
    int n;
    n = 0;
    while (round_over !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (round_over !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL round_over_timeout: got 0 after %0d cycles, expected 1", n);
    end
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_bid_err"}, 64'(bid_err), 64'd0);
    check({tag, "_win"}, 64'(win), 64'd0);
    check({tag, "_round_active"}, 64'(round_active), 64'd0);
    check({tag, "_round_over"}, 64'(round_over), 64'd0);
    check({tag, "_max_bid"}, 64'(max_bid), 64'd0);
    check({tag, "_dup_bids"}, 64'(dup_bids), 64'd0);
    for (int i = 0; i < N; i++) check($sformatf("%s_balance%0d", tag, i), 64'(bal_of(i)), 64'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_idx = '0; cfg_data = '0; mask = 3'b111;
    timer = '0; bid_charge = '0; round_start = 1'b0; bid = '0; retract = '0; bid_amt = '0;
    cycle(); cycle(); cycle();
    reset = 1'b0;
    check_all_zero("reset");

    // Single bid: 100 - (30 + 1) = 69; lone bidder wins at 30.
    load3(100, 50, 20);
    start_round(10, 1);
    expect_ack(0, NOBIDERROR, 1'b1, 69);
    request(3'b001, 3'b000, 30, 0, 0);
    expect_round(3'b001, 30, 1'b0, 69, 50, 20);
    wait_round_over();

    // Three simultaneous bids from ptr=0 are served 0,1,2; bidder2 needs 31 of 20.
    do_reset();
    load3(100, 50, 20);
    start_round(10, 1);
    expect_ack(0, NOBIDERROR, 1'b1, 89);
    expect_ack(1, NOBIDERROR, 1'b1, 29);
    expect_ack(2, INSUFFICIENTFUNDS, 1'b1, 20);
    request(3'b111, 3'b000, 10, 20, 30);
    expect_round(3'b010, 20, 1'b0, 99, 29, 20);
    wait_round_over();

    // Masked bidder rejected; retract refunds the bid but not the fee; empty retract is harmless.
    load3(100, 50, 20);
    mask = 3'b101;
    start_round(20, 1);
    expect_ack(1, INVALIDREQUEST, 1'b1, 50);
    request(3'b010, 3'b000, 0, 5, 0);
    expect_ack(0, NOBIDERROR, 1'b1, 89);
    request(3'b001, 3'b000, 10, 0, 0);
    expect_ack(0, NOBIDERROR, 1'b1, 99);
    request(3'b000, 3'b001, 0, 0, 0);
    expect_ack(0, NOBIDERROR, 1'b1, 99);
    request(3'b000, 3'b001, 0, 0, 0);
    expect_round(3'b000, 0, 1'b0, 99, 50, 20);
    wait_round_over();

    // Pointer now sits at 1 (last grant was bidder 0), so bidder1 is served first.
    mask = 3'b111;
    load3(100, 50, 20);
    start_round(20, 1);
    expect_ack(1, NOBIDERROR, 1'b1, 24);
    expect_ack(0, NOBIDERROR, 1'b1, 59);
    request(3'b011, 3'b000, 40, 25, 0);
    expect_round(3'b001, 40, 1'b0, 59, 49, 20);
    wait_round_over();

    // Tie at 20: no winner, every bid refunded; bid+retract together acts as a bid.
    load3(100, 50, 20);
    start_round(20, 1);
    expect_ack(0, NOBIDERROR, 1'b1, 79);
    request(3'b001, 3'b000, 20, 0, 0);
    expect_ack(1, NOBIDERROR, 1'b1, 29);
    request(3'b010, 3'b000, 0, 20, 0);
    expect_ack(2, NOBIDERROR, 1'b1, 14);
    request(3'b100, 3'b100, 0, 0, 5);
    expect_round(3'b000, 20, 1'b1, 99, 49, 19);
    wait_round_over();

    // Bid outside a round bounces; a zero-length round never starts; reset aborts a live round.
    expect_ack(2, ROUNDINACTIVE, 1'b0, 0);
    request(3'b100, 3'b000, 0, 0, 7);
    start_round(0, 1);
    cycle();
    check("zero_timer_ignored", 64'(round_active), 64'd0);
    start_round(20, 1);
    check("round_active_after_start", 64'(round_active), 64'd1);
    expect_ack(0, NOBIDERROR, 1'b1, 68);
    request(3'b001, 3'b000, 30, 0, 0);
    reset = 1'b1;
    cycle();
    check_all_zero("mid_round_reset");
    reset = 1'b0;
    cycle();

    check("ack_queue_drained", 64'(ackq.size()), 64'd0);
    check("round_queue_drained", 64'(roundq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
